// File: rtl/guess_autoplayer.sv
// Automated responder for the guess game: watches the LED output y and presses the
// matching button after a programmable reaction delay, counting missed reactions.
module guess_autoplayer #(
  parameter int DW   = 8,
  parameter int HOLD = 4,
  parameter int MW   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    target,
  input  logic [DW-1:0] delay,
  input  logic [3:0]    y,
  input  logic          win,
  input  logic          lose,
  output logic [3:0]    B,
  output logic          busy,
  output logic          hit,
  output logic [MW-1:0] miss_cnt
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_REACT, S_PRESS, S_DONE} state_t;

  state_t          state, state_nx;
  logic [1:0]      tgt, tgt_nx;
  logic [DW-1:0]   dly, dly_nx;
  logic [DW-1:0]   cnt, cnt_nx;
  logic [HW-1:0]   hcnt, hcnt_nx;
  logic [MW-1:0]   miss, miss_nx;
  logic            hit_q, hit_nx;
  logic [3:0]      tgt_pat;
  logic            match;
  logic            game_over;

  function automatic logic [MW-1:0] sat_inc(input logic [MW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign tgt_pat   = 4'b0001 << tgt;
  // Non-one-hot y (1111/0000) can never equal a one-hot pattern, so no extra guard.
  assign match     = (y == tgt_pat);
  assign game_over = win | lose;

  assign B        = (state == S_PRESS) ? tgt_pat : 4'b0000;
  assign busy     = (state != S_IDLE);
  assign hit      = hit_q;
  assign miss_cnt = miss;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      tgt   <= '0;
      dly   <= '0;
      cnt   <= '0;
      hcnt  <= '0;
      miss  <= '0;
      hit_q <= 1'b0;
    end else begin
      state <= state_nx;
      tgt   <= tgt_nx;
      dly   <= dly_nx;
      cnt   <= cnt_nx;
      hcnt  <= hcnt_nx;
      miss  <= miss_nx;
      hit_q <= hit_nx;
    end
  end

  always_comb begin
    state_nx = state;
    tgt_nx   = tgt;
    dly_nx   = dly;
    cnt_nx   = cnt;
    hcnt_nx  = hcnt;
    miss_nx  = miss;
    hit_nx   = hit_q;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          tgt_nx   = target;
          dly_nx   = delay;
          hit_nx   = 1'b0;
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (game_over) begin
          state_nx = S_DONE;
        end else if (match) begin
          cnt_nx   = dly;
          state_nx = S_REACT;
        end
      end
      S_REACT: begin
        // Losing the match before the delay expires is a miss; it outranks cnt==0.
        if (game_over) begin
          state_nx = S_DONE;
        end else if (!match) begin
          miss_nx  = sat_inc(miss);
          state_nx = S_WAIT;
        end else if (cnt == '0) begin
          hcnt_nx  = HW'(HOLD - 1);
          state_nx = S_PRESS;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      S_PRESS: begin
        if (game_over || hcnt == '0) begin
          state_nx = S_DONE;
        end else begin
          hcnt_nx = hcnt - 1'b1;
        end
      end
      S_DONE: begin
        if (win) begin
          hit_nx   = 1'b1;
          state_nx = S_IDLE;
        end else if (lose) begin
          hit_nx   = 1'b0;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_guess_autoplayer.sv
// Directed bench for guess_autoplayer: reaction latency, press width, misses,
// saturation, start-while-busy, async reset and early win/lose termination.
module tb_guess_autoplayer;

  localparam int DW   = 8;
  localparam int HOLD = 4;
  localparam int MW   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    target;
  logic [DW-1:0] delay;
  logic [3:0]    y;
  logic          win;
  logic          lose;
  logic [3:0]    B;
  logic          busy;
  logic          hit;
  logic [MW-1:0] miss_cnt;

  int n_cmp = 0;
  int n_err = 0;

  guess_autoplayer #(.DW(DW), .HOLD(HOLD), .MW(MW)) dut (
    .clk(clk), .rst(rst), .start(start), .target(target), .delay(delay),
    .y(y), .win(win), .lose(lose), .B(B), .busy(busy), .hit(hit),
    .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic [1:0] t, input logic [DW-1:0] d);
    target = t;
    delay  = d;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  initial begin
    logic    any_b;
    logic [3:0] exp_b;
    rst = 1'b1; start = 0; target = 0; delay = 0; y = 0; win = 0; lose = 0;
    #1;
    chk("rst_B", B, 0);
    chk("rst_busy", busy, 0);
    chk("rst_hit", hit, 0);
    chk("rst_miss", miss_cnt, 0);
    tick();
    rst = 1'b0;
    tick();

    // 1: target 2, delay 3 -> press in cycles 5..8
    arm(2'd2, 8'd3);
    chk("t1_busy", busy, 1);
    y = 4'b0100;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) tick();
      exp_b = (c >= 5 && c <= 8) ? 4'b0100 : 4'b0000;
      chk($sformatf("t1_B_c%0d", c), B, exp_b);
    end
    chk("t1_done_busy", busy, 1);
    win = 1'b1;
    tick();
    win = 1'b0;
    chk("t1_hit", hit, 1);
    chk("t1_idle", busy, 0);
    chk("t1_miss", miss_cnt, 0);

    // 2: rotating y with dwell shorter than the delay -> one miss per pass
    y = 4'b0000;
    arm(2'd1, 8'd10);
    any_b = 1'b0;
    for (int p = 0; p < 20; p++) begin
      for (int i = 0; i < 4; i++) begin
        y = 4'b0001 << i;
        for (int k = 0; k < 4; k++) begin
          tick();
          any_b = any_b | (|B);
        end
      end
      if (p == 4) chk("t2_miss_5", miss_cnt, 5);
      if (p == 14) chk("t2_miss_15", miss_cnt, 15);
    end
    chk("t2_miss_sat", miss_cnt, 15);
    chk("t2_no_press", any_b, 0);
    y = 4'b0000;
    lose = 1'b1;
    tick();
    tick();
    lose = 1'b0;
    chk("t2_idle", busy, 0);

    // 3: delay 0 -> press from cycle 2; start during PRESS ignored
    arm(2'd3, 8'd0);
    y = 4'b1000;
    tick();
    chk("t3_B_c1", B, 0);
    tick();
    chk("t3_B_c2", B, 4'b1000);
    target = 2'd0; delay = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t3_B_c3", B, 4'b1000);
    tick();
    chk("t3_B_c4", B, 4'b1000);
    tick();
    chk("t3_B_c5", B, 4'b1000);
    tick();
    chk("t3_B_c6", B, 0);
    chk("t3_busy", busy, 1);
    win = 1'b1;
    tick();
    win = 1'b0;
    chk("t3_hit", hit, 1);

    // 4: async reset between edges while pressing
    y = 4'b0001;
    arm(2'd0, 8'd1);
    tick();
    tick();
    tick();
    chk("t4_B_press", B, 4'b0001);
    chk("t4_miss_pre", miss_cnt, 15);
    #2 rst = 1'b1;
    #1;
    chk("t4_B_rst", B, 0);
    chk("t4_busy_rst", busy, 0);
    chk("t4_miss_rst", miss_cnt, 0);
    chk("t4_hit_rst", hit, 0);
    #1 rst = 1'b0;
    tick();

    // 5: lose while waiting
    y = 4'b0000;
    arm(2'd1, 8'd2);
    lose = 1'b1;
    tick();
    chk("t5_done_busy", busy, 1);
    chk("t5_done_B", B, 0);
    tick();
    lose = 1'b0;
    chk("t5_idle", busy, 0);
    chk("t5_hit", hit, 0);

    // 6: win on second PRESS cycle ends the press early
    y = 4'b0100;
    arm(2'd2, 8'd0);
    tick();
    tick();
    chk("t6_B_p1", B, 4'b0100);
    tick();
    chk("t6_B_p2", B, 4'b0100);
    win = 1'b1;
    tick();
    chk("t6_B_after", B, 0);
    chk("t6_done_busy", busy, 1);
    tick();
    win = 1'b0;
    chk("t6_hit", hit, 1);
    chk("t6_idle", busy, 0);
    arm(2'd2, 8'd0);
    chk("t6_hit_clr", hit, 0);
    chk("t6_rearm_busy", busy, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
